// File: rtl/fetch_stage.sv
// RV32I fetch stage: PC register, next-PC select and IF/ID pipeline register.
// Optional perf counters (fetch_cnt, redirect_cnt) enabled by `define FETCH_PERF_EN.
module fetch_stage #(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_PC  = '0,
    parameter logic [31:0]      NOP_INSTR = 32'h0000_0013
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall_f,
    input  logic             stall_d,
    input  logic             flush_d,
    input  logic             pc_src_e,
    input  logic [WIDTH-1:0] pc_target_e,
    output logic [WIDTH-1:0] imem_addr,
    input  logic [WIDTH-1:0] imem_rdata,
    output logic [WIDTH-1:0] pc_f,
    output logic [31:0]      instr_d,
    output logic [WIDTH-1:0] pc_d,
    output logic [WIDTH-1:0] pcplus4_d,
    output logic             valid_d
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]      fetch_cnt,
    output logic [31:0]      redirect_cnt
`endif
);

    logic [WIDTH-1:0] pc_plus4;
    logic [WIDTH-1:0] pc_next;
    logic             capture;

    assign pc_plus4  = pc_f + WIDTH'(4);
    assign imem_addr = pc_f;
    assign capture   = !flush_d && !stall_d;

    // Redirect wins over stall so a resolved branch is never dropped.
    always_comb begin
        pc_next = pc_plus4;
        if (pc_src_e) begin
            pc_next = {pc_target_e[WIDTH-1:2], 2'b00};
        end else if (stall_f) begin
            pc_next = pc_f;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_f <= RESET_PC;
        end else begin
            pc_f <= pc_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush_d) begin
            instr_d   <= NOP_INSTR;
            pc_d      <= '0;
            pcplus4_d <= '0;
            valid_d   <= 1'b0;
        end else if (!stall_d) begin
            instr_d   <= imem_rdata[31:0];
            pc_d      <= pc_f;
            pcplus4_d <= pc_plus4;
            valid_d   <= 1'b1;
        end
    end

`ifdef FETCH_PERF_EN
    // Saturating counters: stick at all-ones rather than wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_cnt    <= '0;
            redirect_cnt <= '0;
        end else begin
            if (capture && fetch_cnt != '1) begin
                fetch_cnt <= fetch_cnt + 32'd1;
            end
            if (pc_src_e && redirect_cnt != '1) begin
                redirect_cnt <= redirect_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios then random
// stall/flush/redirect traffic against a cycle-level reference model.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst, stall_f, stall_d, flush_d, pc_src_e;
    logic [31:0] pc_target_e, imem_addr, imem_rdata, pc_f;
    logic [31:0] instr_d, pc_d, pcplus4_d;
    logic        valid_d;
`ifdef FETCH_PERF_EN
    logic [31:0] fetch_cnt, redirect_cnt;
`endif

    int checks = 0;
    int passed = 0;

    logic [31:0] m_pc, m_instr, m_pcd, m_pc4;
    logic        m_valid;
    logic [31:0] m_fc, m_rc;

    always #5 clk = ~clk;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
    endfunction

    assign imem_rdata = mem(imem_addr);

    fetch_stage dut (
        .clk(clk), .rst(rst), .stall_f(stall_f), .stall_d(stall_d),
        .flush_d(flush_d), .pc_src_e(pc_src_e), .pc_target_e(pc_target_e),
        .imem_addr(imem_addr), .imem_rdata(imem_rdata), .pc_f(pc_f),
        .instr_d(instr_d), .pc_d(pc_d), .pcplus4_d(pcplus4_d),
        .valid_d(valid_d)
`ifdef FETCH_PERF_EN
        , .fetch_cnt(fetch_cnt), .redirect_cnt(redirect_cnt)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // One clock: model computes the next state from the spec's rules.
    task automatic step(input bit r, sf, sd, fl, ps,
                        input logic [31:0] tg);
        logic [31:0] n_pc;
        rst = r; stall_f = sf; stall_d = sd; flush_d = fl;
        pc_src_e = ps; pc_target_e = tg;
        if (r) n_pc = 32'h0;
        else if (ps) n_pc = tg & 32'hFFFF_FFFC;
        else if (sf) n_pc = m_pc;
        else n_pc = m_pc + 32'd4;
        if (r || fl) begin
            m_instr = 32'h13; m_pcd = 0; m_pc4 = 0; m_valid = 0;
        end else if (!sd) begin
            m_instr = mem(m_pc); m_pcd = m_pc;
            m_pc4 = m_pc + 32'd4; m_valid = 1;
        end
        if (r) begin
            m_fc = 0; m_rc = 0;
        end else begin
            if (!fl && !sd && m_fc != 32'hFFFF_FFFF) m_fc++;
            if (ps && m_rc != 32'hFFFF_FFFF) m_rc++;
        end
        m_pc = n_pc;
        @(posedge clk);
        #1;
        chk("pc_f", pc_f, m_pc);
        chk("imem_addr", imem_addr, m_pc);
        chk("instr_d", instr_d, m_instr);
        chk("pc_d", pc_d, m_pcd);
        chk("pcplus4_d", pcplus4_d, m_pc4);
        chk("valid_d", {31'b0, valid_d}, {31'b0, m_valid});
`ifdef FETCH_PERF_EN
        chk("fetch_cnt", fetch_cnt, m_fc);
        chk("redirect_cnt", redirect_cnt, m_rc);
`endif
    endtask

    initial begin
        m_pc = 0; m_instr = 0; m_pcd = 0; m_pc4 = 0; m_valid = 0;
        m_fc = 0; m_rc = 0;
        // Reset then run
        step(1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        chk("rst_pc", pc_f, 32'h0);
        chk("rst_instr", instr_d, 32'h13);
        step(0, 0, 0, 0, 0, 0);
        chk("first_valid", {31'b0, valid_d}, 32'd1);
        chk("first_instr", instr_d, mem(32'h0));
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        chk("pc_at_10", pc_f, 32'h10);
        // Redirect with flush, misaligned target
        step(0, 0, 0, 1, 1, 32'h0000_0103);
        chk("redir_pc", pc_f, 32'h100);
        chk("redir_bubble", instr_d, 32'h13);
        // Stall two cycles at 0x20
        step(0, 0, 0, 1, 1, 32'h20);
        step(0, 0, 0, 0, 0, 0);
        step(0, 1, 1, 0, 0, 0);
        step(0, 1, 1, 0, 0, 0);
        chk("stall_pc", pc_f, 32'h24);
        chk("stall_pcd", pc_d, 32'h20);
        step(0, 0, 0, 0, 0, 0);
        chk("release_pc", pc_f, 32'h28);
        // Redirect during stall; flush beats stall_d
        step(0, 1, 1, 1, 1, 32'h200);
        chk("redir_stall_pc", pc_f, 32'h200);
        chk("flush_stall_valid", {31'b0, valid_d}, 32'd0);
        // Wrap-around
        step(0, 0, 0, 1, 1, 32'hFFFF_FFFC);
        step(0, 0, 0, 0, 0, 0);
        chk("wrap_pc", pc_f, 32'h0);
        chk("wrap_pc4", pcplus4_d, 32'h0);
        chk("wrap_pcd", pc_d, 32'hFFFF_FFFC);
        // Duplicate-capture corner: stall_f without stall_d
        step(0, 1, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0);
        // Mid-run reset at 0x40 with valid_d=1
        step(0, 0, 0, 1, 1, 32'h3C);
        step(0, 0, 0, 0, 0, 0);
        chk("pre_rst_pc", pc_f, 32'h40);
        step(1, 0, 0, 0, 0, 0);
        chk("midrst_pc", pc_f, 32'h0);
        chk("midrst_instr", instr_d, 32'h13);
`ifdef FETCH_PERF_EN
        chk("midrst_fc", fetch_cnt, 32'h0);
        chk("midrst_rc", redirect_cnt, 32'h0);
`endif
        // Random traffic
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 49) == 0),
                 ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 5) == 0),
                 ($urandom_range(0, 5) == 0),
                 $urandom);
        end
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
